ram_sync_param: RTL

//  Parametrised single-port synchronous RAM: WIDTH-bit words, DEPTH entries, one clock.

---
 rtl/ram_sync_param.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ram_sync_param.sv
// ============================================================================
// Module      : ram_sync_param
// Description : Single-port synchronous RAM, WIDTH x DEPTH, with a registered
//               read port and valid strobe, plus a clear sequencer that walks
//               every address writing zero.
//               Optional build macro RAM_PARITY_EN adds a stored even-parity
//               bit per word and reports a registered parity error on reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sync_param #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  d_in,
  input  logic              clr,
  output logic [WIDTH-1:0]  d_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              parity_err
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
`ifdef RAM_PARITY_EN
  logic              par [DEPTH];
`endif

  logic [0:0]        state_q,      state_d;
  logic [ADDR_W-1:0] ptr_q,        ptr_d;
  logic [WIDTH-1:0]  d_out_q,      d_out_d;
  logic              rd_valid_q,   rd_valid_d;
  logic              parity_err_q, parity_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WIDTH-1:0]  mem_wdata;

  // Next-state, read-data and memory write-port selection
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    d_out_d      = d_out_q;
    rd_valid_d   = 1'b0;
    parity_err_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = addr;
    mem_wdata    = d_in;
    case (state_q)
      CLEAR: begin
        // Host accesses and clr are ignored while the sequencer owns the array
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + ADDR_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        if (clr) begin
          // clr takes priority; any access presented alongside it is dropped
          state_d = CLEAR;
          ptr_d   = '0;
        end else if (cs) begin
          if (rw) begin
            mem_we = 1'b1;
          end else begin
            d_out_d    = mem[addr];
            rd_valid_d = 1'b1;
`ifdef RAM_PARITY_EN
            parity_err_d = ^{mem[addr], par[addr]};
`endif
          end
        end
      end
    endcase
  end

  // Control and read-port registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      d_out_q      <= '0;
      rd_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      d_out_q      <= d_out_d;
      rd_valid_q   <= rd_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Storage array; no reset, contents are zeroed by the clear sequencer
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
`ifdef RAM_PARITY_EN
      par[mem_waddr] <= ^mem_wdata;
`endif
    end
  end

  assign d_out      = d_out_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = (state_q == CLEAR);
  assign parity_err = parity_err_q;

endmodule

`default_nettype wire
